mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 10 +
 rtl/dma_addr_gen.sv | 30 +++
 rtl/mem_arbiter.sv | 78 +++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and sizing constants for the memory arbiter
package mem_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int BURST_MAX = 16;
  typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_RSP, DMA_ACC, DMA_RSP} state_t;
  function automatic logic [4:0] burst_words(input logic [3:0] len);
    return (len == 4'd0) ? 5'(BURST_MAX) : {1'b0, len};
  endfunction
endpackage

// File: rtl/dma_addr_gen.sv
// dma_addr_gen: burst word address incrementer and remaining-word counter
module dma_addr_gen
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start,
  input  logic [3:0]        len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [4:0] left;
  // Load takes the burst start and size; step moves to the next word, wrapping past all-ones
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr <= '0;
      left <= '0;
    end else if (load) begin
      addr <= start;
      left <= burst_words(len);
    end else if (step) begin
      addr <= addr + 1'b1;
      left <= left - 1'b1;
    end
  assign last = left == 5'd1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin single-port RAM arbiter between CPU word accesses and DMA bursts
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [3:0]        dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  state_t state;
  logic last_dma, burst_we, cpu_win, load, step, last;
  logic [ADDR_W-1:0] burst_addr;
  assign cpu_win = cpu_req && (!dma_req || last_dma);
  assign load = state == IDLE && dma_req && !cpu_win;
  assign step = state == DMA_RSP && !last;
  dma_addr_gen #(.ADDR_W(ADDR_W)) u_gen (
    .clk(clk), .reset(reset), .load(load), .step(step),
    .start(dma_addr), .len(dma_len), .addr(burst_addr), .last(last)
  );
  // Sequencer: grants in IDLE only, then runs one access/response pair per word
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      last_dma <= 1'b1;
      burst_we <= 1'b0;
      cpu_ack  <= 1'b0;
      dma_ack  <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      cpu_ack  <= state == CPU_ACC;
      dma_ack  <= state == DMA_ACC;
      dma_done <= state == DMA_ACC && last;
      case (state)
        IDLE:
          if (cpu_win) begin
            state    <= CPU_ACC;
            last_dma <= 1'b0;
          end else if (dma_req) begin
            state    <= DMA_ACC;
            last_dma <= 1'b1;
            burst_we <= dma_we;
          end
        CPU_ACC: state <= CPU_RSP;
        CPU_RSP: state <= IDLE;
        DMA_ACC: state <= DMA_RSP;
        DMA_RSP: state <= last ? IDLE : DMA_ACC;
        default: state <= IDLE;
      endcase
    end
  assign ram_en    = state == CPU_ACC || state == DMA_ACC;
  assign ram_we    = state == CPU_ACC ? cpu_we : (state == DMA_ACC && burst_we);
  assign ram_addr  = state == CPU_ACC ? cpu_addr : state == DMA_ACC ? burst_addr : '0;
  assign ram_wdata = state == CPU_ACC ? cpu_wdata : state == DMA_ACC ? dma_wdata : '0;
  assign cpu_rdata = cpu_ack ? ram_rdata : '0;
  assign dma_rdata = dma_ack ? ram_rdata : '0;
  assign cpu_wait  = cpu_req & ~cpu_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a phase-counting model
module tb_mem_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;
  logic clk = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic cpu_ack, cpu_wait;
  logic [DW-1:0] cpu_rdata;
  logic dma_req = 0, dma_we = 0;
  logic [AW-1:0] dma_addr = '0;
  logic [3:0] dma_len = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic dma_ack, dma_done;
  logic [DW-1:0] dma_rdata;
  logic ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // Bench RAM: synchronous write, read data one cycle after the strobe
  logic [DW-1:0] ram [0:65535];
  bit ram_v [0:65535];
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) begin
        ram[ram_addr] <= ram_wdata;
        ram_v[ram_addr] <= 1'b1;
      end else ram_rdata <= ram_v[ram_addr] ? ram[ram_addr] : fill(ram_addr);
    end

  logic [DW-1:0] ref_mem [0:65535];
  bit ref_v [0:65535];
  int nvec = 0, nbad = 0, cyc = 0;
  int owner = 0, k = 0, n = 0;
  logic [AW-1:0] mstart = '0;
  logic mwe = 0, mlast_dma = 1;
  bit rand_en = 0;
  bit cpu_pend = 0, dma_pend = 0, dma_active = 0;
  logic p_cwe, p_dwe;
  logic [AW-1:0] p_caddr, p_daddr;
  logic [DW-1:0] p_cwdata;
  logic [3:0] p_dlen;
  logic [DW-1:0] p_bdata [16];
  logic [DW-1:0] bdata [16];
  int bidx = 0;

  function automatic logic [DW-1:0] refrd(input logic [AW-1:0] a);
    return ref_v[a] ? ref_mem[a] : fill(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_rst();
    owner = 0;
    k = 0;
    mlast_dma = 1;
  endtask

  // Expected outputs follow from the position inside the current transaction:
  // a CPU access is 2 cycles (access, ack); a burst of n words is 2n cycles alternating.
  task automatic model_step();
    logic e_en, e_we, e_ca, e_da, e_dd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    e_en = (owner == 1 && k == 0) || (owner == 2 && k % 2 == 0);
    e_we = e_en && (owner == 1 ? cpu_we : mwe);
    e_addr = owner == 1 ? cpu_addr : mstart + AW'(k / 2);
    e_wd = owner == 1 ? cpu_wdata : bdata[(k / 2) % 16];
    e_ca = owner == 1 && k == 1;
    e_da = owner == 2 && k % 2 == 1;
    e_dd = e_da && k == 2 * n - 1;
    chk("ram_en", ram_en, e_en);
    chk("ram_we", ram_we, e_we);
    if (e_en) chk("ram_addr", ram_addr, e_addr);
    if (e_we) chk("ram_wdata", ram_wdata, e_wd);
    chk("cpu_ack", cpu_ack, e_ca);
    chk("dma_ack", dma_ack, e_da);
    chk("dma_done", dma_done, e_dd);
    chk("cpu_wait", cpu_wait, cpu_req && !e_ca);
    if (e_ca && !cpu_we) chk("cpu_rdata", cpu_rdata, refrd(cpu_addr));
    if (e_da && !mwe) chk("dma_rdata", dma_rdata, refrd(e_addr));
    if (e_we) begin
      ref_mem[e_addr] = e_wd;
      ref_v[e_addr] = 1;
    end
    if (reset) model_rst();
    else if (owner == 0) begin
      if (cpu_req && (!dma_req || mlast_dma)) begin
        owner = 1;
        k = 0;
        mlast_dma = 0;
      end else if (dma_req) begin
        owner = 2;
        k = 0;
        mstart = dma_addr;
        n = dma_len == 0 ? 16 : int'(dma_len);
        mwe = dma_we;
        mlast_dma = 1;
      end
    end else begin
      k++;
      if ((owner == 1 && k == 2) || (owner == 2 && k == 2 * n)) owner = 0;
    end
  endtask

  task automatic tick();
    logic ca, da, dd;
    ca = cpu_ack;
    da = dma_ack;
    dd = dma_done;
    @(posedge clk);
    #1;
    if (ca) begin
      if (cpu_pend) begin
        cpu_we = p_cwe; cpu_addr = p_caddr; cpu_wdata = p_cwdata; cpu_pend = 0;
      end else cpu_req = 0;
    end else if (!cpu_req && cpu_pend) begin
      cpu_req = 1; cpu_we = p_cwe; cpu_addr = p_caddr; cpu_wdata = p_cwdata; cpu_pend = 0;
    end else if (!cpu_req && rand_en && $urandom_range(0, 3) == 0) begin
      cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = AW'($urandom_range(0, 31)); cpu_wdata = DW'($urandom);
    end
    if (da) begin
      bidx++;
      if (dd) begin
        dma_active = 0;
        dma_req = 0;
      end
    end else if (dma_active && dma_req && rand_en && $urandom_range(0, 7) == 0) dma_req = 0;
    if (!dma_active && dma_pend) begin
      dma_req = 1; dma_we = p_dwe; dma_addr = p_daddr; dma_len = p_dlen;
      for (int i = 0; i < 16; i++) bdata[i] = p_bdata[i];
      bidx = 0; dma_active = 1; dma_pend = 0;
    end else if (!dma_active && rand_en && $urandom_range(0, 5) == 0) begin
      dma_req = 1; dma_we = 1'($urandom); dma_len = 4'($urandom);
      dma_addr = $urandom_range(0, 3) == 0 ? 16'hFFF8 : AW'($urandom_range(0, 40));
      for (int i = 0; i < 16; i++) bdata[i] = DW'($urandom);
      bidx = 0; dma_active = 1;
    end
    dma_wdata = bdata[bidx % 16];
    cyc++;
    #1;
    model_step();
  endtask

  task automatic cpu_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_cwe = we; p_caddr = a; p_cwdata = d; cpu_pend = 1;
  endtask

  task automatic dma_cmd(input logic we, input logic [AW-1:0] a, input logic [3:0] l, input logic [DW-1:0] d0);
    p_dwe = we; p_daddr = a; p_dlen = l;
    for (int i = 0; i < 16; i++) p_bdata[i] = d0 * DW'(i + 1);
    dma_pend = 1;
  endtask

  initial begin
    int acks, done_at, done_cyc, ack_cyc;
    bit early, raised;
    logic [AW-1:0] aq [$];
    repeat (3) tick();
    chk("reset_ram_en", ram_en, 0);
    chk("reset_cpu_ack", cpu_ack, 0);
    chk("reset_dma_done", dma_done, 0);
    reset = 0;
    // First tie after reset: CPU wins; CPU re-requests back-to-back so the next tie goes to DMA
    cpu_cmd(1, 16'h0010, 16'hBEEF);
    dma_cmd(0, 16'h0020, 4'd2, 16'h0000);
    tick();
    tick();
    chk("tie1_addr", ram_addr, 16'h0010);
    chk("tie1_we", ram_we, 1);
    cpu_cmd(1, 16'h0011, 16'h1234);
    tick();
    tick();
    tick();
    chk("tie2_addr", ram_addr, 16'h0020);
    chk("tie2_we", ram_we, 0);
    chk("tie2_cpu_wait", cpu_wait, 1);
    repeat (12) tick();
    // CPU read of 0x0010 holding 0xBEEF
    cpu_cmd(0, 16'h0010, 16'h0000);
    tick();
    tick();
    chk("rd_en_c1", ram_en, 1);
    chk("rd_addr_c1", ram_addr, 16'h0010);
    tick();
    chk("rd_ack_c2", cpu_ack, 1);
    chk("rd_data_c2", cpu_rdata, 16'hBEEF);
    tick();
    chk("rd_wait_after", cpu_wait, 0);
    // DMA write burst of 3 at 0x0100
    dma_cmd(1, 16'h0100, 4'd3, 16'h1111);
    acks = 0; done_at = 0; aq = {};
    for (int i = 0; i < 20 && done_at == 0; i++) begin
      tick();
      if (ram_en && ram_we) aq.push_back(ram_addr);
      if (dma_ack) acks++;
      if (dma_done) done_at = acks;
    end
    chk("w3_count", aq.size(), 3);
    if (aq.size() == 3) begin
      chk("w3_a0", aq[0], 16'h0100);
      chk("w3_a2", aq[2], 16'h0102);
    end
    chk("w3_acks", acks, 3);
    chk("w3_done_on", done_at, 3);
    cpu_cmd(0, 16'h0101, 16'h0000);
    repeat (3) tick();
    chk("w3_readback", cpu_rdata, 16'h2222);
    tick();
    // len=0 read burst wrapping the address space
    dma_cmd(0, 16'hFFFE, 4'd0, 16'h0000);
    done_at = 0; aq = {};
    for (int i = 0; i < 40 && done_at == 0; i++) begin
      tick();
      if (ram_en) aq.push_back(ram_addr);
      if (dma_done) done_at = 1;
    end
    chk("b16_count", aq.size(), 16);
    if (aq.size() == 16) begin
      chk("b16_a0", aq[0], 16'hFFFE);
      chk("b16_a1", aq[1], 16'hFFFF);
      chk("b16_a2", aq[2], 16'h0000);
      chk("b16_a15", aq[15], 16'h000D);
    end
    tick();
    // CPU request during a burst waits until after dma_done
    dma_cmd(0, 16'h0040, 4'd4, 16'h0000);
    acks = 0; raised = 0; early = 0; done_cyc = 0; ack_cyc = 0;
    for (int i = 0; i < 40 && ack_cyc == 0; i++) begin
      tick();
      if (dma_ack) acks++;
      if (cpu_ack && done_cyc == 0) early = 1;
      if (cpu_ack) ack_cyc = cyc;
      if (dma_done) begin
        done_cyc = cyc;
        chk("wait_at_done", cpu_wait, 1);
      end
      if (acks == 1 && !raised) begin
        cpu_cmd(0, 16'h0041, 16'h0000);
        raised = 1;
      end
    end
    chk("no_early_ack", early, 0);
    chk("cpu_after_done", ack_cyc - done_cyc, 3);
    repeat (2) tick();
    // Reset during a DMA access abandons the burst
    dma_cmd(1, 16'h0800, 4'd5, 16'h0101);
    for (int i = 0; i < 10 && !ram_en; i++) tick();
    chk("pre_rst_en", ram_en, 1);
    reset = 1;
    #1;
    chk("rst_en_now", ram_en, 0);
    chk("rst_we_now", ram_we, 0);
    chk("rst_ack_now", dma_ack, 0);
    dma_req = 0; dma_active = 0; dma_pend = 0; cpu_req = 0; cpu_pend = 0;
    model_rst();
    tick();
    chk("rst_no_ack", dma_ack, 0);
    reset = 0;
    repeat (3) tick();
    chk("idle_after_rst", ram_en, 0);
    // Randomized traffic
    rand_en = 1;
    repeat (600) tick();
    rand_en = 0;
    repeat (60) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
